// File: rtl/spi_bridge_pkg.sv
// spi_bridge_pkg: shared FSM state type and command-byte field positions for spi_reg_bridge
package spi_bridge_pkg;
  localparam int CMD_RD_BIT = 7;
  typedef enum logic [2:0] {IDLE, CMD, WR_DATA, RD_TURN, RD_DATA, DROP} state_t;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for one asynchronous bit, resets to 1 (idle level)
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk)
    if (rst) {q, m} <= 2'b11;
    else {q, m} <= {m, d};
endmodule

// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge: SPI byte stream to register bus bridge, one frame per ss-low period.
// Define SPI_BURST_EN for auto-incrementing multi-byte reads/writes; otherwise one data byte per frame.
module spi_reg_bridge
  import spi_bridge_pkg::*;
#(
  parameter int         ADDR_W      = 7,
  parameter logic [7:0] STATUS_BYTE = 8'hA5,
  parameter logic [7:0] TURN_BYTE   = 8'h00
) (
  input  logic              ext_clk,
  input  logic              rst,
  input  logic              ss,
  input  logic [7:0]        recv_data,
  input  logic              recv_ready,
  input  logic              send_ready,
  output logic [7:0]        send_data,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [7:0]        reg_rdata,
  output logic              busy
);
`ifdef SPI_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif
  state_t            state;
  logic              ss_s, seen_hi, re_d;
  logic [1:0]        warm;
  logic [ADDR_W-1:0] addr, addr_n;
  logic [7:0]        pf;
  assign addr_n = addr + 1'b1;
  sync_2ff u_ss_sync (.clk(ext_clk), .rst(rst), .d(ss), .q(ss_s));
  // warm hides the synchroniser's reset value so a frame already in progress at reset is never joined
  always_ff @(posedge ext_clk)
    if (rst) begin
      state     <= IDLE;
      send_data <= '0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      busy      <= 1'b0;
      addr      <= '0;
      pf        <= '0;
      re_d      <= 1'b0;
      warm      <= '0;
      seen_hi   <= 1'b0;
    end else begin
      reg_we <= 1'b0;
      reg_re <= 1'b0;
      re_d   <= reg_re;
      warm   <= {warm[0], 1'b1};
      if (re_d) pf <= reg_rdata;
      if (state == IDLE) begin
        if (send_ready) send_data <= STATUS_BYTE;
        if (ss_s && warm[1]) seen_hi <= 1'b1;
        if (!ss_s && seen_hi) begin
          state <= CMD;
          busy  <= 1'b1;
        end
      end else begin
        if (state == DROP && send_ready) send_data <= TURN_BYTE;
        if (recv_ready)
          case (state)
            CMD: begin
              addr     <= recv_data[ADDR_W-1:0];
              reg_addr <= recv_data[ADDR_W-1:0];
              reg_re   <= recv_data[CMD_RD_BIT];
              state    <= recv_data[CMD_RD_BIT] ? RD_TURN : WR_DATA;
              if (recv_data[CMD_RD_BIT]) send_data <= TURN_BYTE;
            end
            WR_DATA: begin
              reg_we    <= 1'b1;
              reg_wdata <= recv_data;
              reg_addr  <= addr;
              addr      <= BURST ? addr_n : addr;
              state     <= BURST ? WR_DATA : DROP;
            end
            RD_TURN, RD_DATA: begin
              send_data <= pf;
              state     <= (BURST || state == RD_TURN) ? RD_DATA : DROP;
              if (BURST) begin
                addr     <= addr_n;
                reg_addr <= addr_n;
                reg_re   <= 1'b1;
              end
            end
            default: ;
          endcase
        if (ss_s) begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      end
    end
endmodule

// File: tb/tb_spi_reg_bridge.sv
// tb_spi_reg_bridge: randomized self-checking bench with a frame-level reference model and register memory
module tb_spi_reg_bridge;
  localparam int AW  = 7;
  localparam int GAP = 20;
`ifdef SPI_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif
  logic          ext_clk = 1'b0, rst = 1'b1, ss = 1'b1, recv_ready = 1'b0, send_ready = 1'b1;
  logic [7:0]    recv_data = '0, reg_rdata = '0;
  logic [7:0]    send_data, reg_wdata;
  logic [AW-1:0] reg_addr;
  logic          reg_we, reg_re, busy;
  logic [7:0]    mem [128];
  logic [AW-1:0] wa [256], ra [256];
  logic [7:0]    wd [256];
  logic [7:0]    fb [8], mo [9];
  int wn = 0, rn = 0, nvec = 0, nfail = 0;

  always #5 ext_clk = ~ext_clk;

  spi_reg_bridge dut (
    .ext_clk(ext_clk), .rst(rst), .ss(ss), .recv_data(recv_data), .recv_ready(recv_ready),
    .send_ready(send_ready), .send_data(send_data), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_we(reg_we), .reg_re(reg_re), .reg_rdata(reg_rdata), .busy(busy)
  );

  always @(posedge ext_clk) begin
    if (reg_re) begin
      reg_rdata      <= mem[reg_addr];
      ra[rn % 256]   <= reg_addr;
      rn             <= rn + 1;
    end
    if (reg_we) begin
      wa[wn % 256] <= reg_addr;
      wd[wn % 256] <= reg_wdata;
      wn           <= wn + 1;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge ext_clk);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic [7:0] nxt);
    idle(GAP);
    recv_data = b; recv_ready = 1'b1; send_ready = 1'b1;
    @(negedge ext_clk);
    recv_ready = 1'b0; send_ready = 1'b0;
    nxt = send_data;
  endtask

  task automatic frame_start();
    ss = 1'b0; send_ready = 1'b0;
    idle(6);
  endtask

  task automatic frame_end();
    idle(GAP);
    ss = 1'b1; send_ready = 1'b1;
    idle(6);
  endtask

  task automatic do_frame(input int n);
    logic [7:0] m;
    mo[0] = send_data;
    frame_start();
    for (int k = 0; k < n; k++) begin
      send_byte(fb[k], m);
      mo[k+1] = m;
    end
    frame_end();
  endtask

  task automatic test_reset();
    idle(3);
    nvec += 5;
    if (send_data !== 8'h00) begin nfail++; $display("FAIL rst_send_data got %h want 00", send_data); end
    if (busy !== 1'b0) begin nfail++; $display("FAIL rst_busy got %b want 0", busy); end
    if (reg_we !== 1'b0 || reg_re !== 1'b0) begin nfail++; $display("FAIL rst_strobes got we=%b re=%b want 0 0", reg_we, reg_re); end
    if (reg_addr !== '0) begin nfail++; $display("FAIL rst_addr got %h want 00", reg_addr); end
    if (reg_wdata !== 8'h00) begin nfail++; $display("FAIL rst_wdata got %h want 00", reg_wdata); end
    rst = 1'b0;
    idle(2);
    nvec += 2;
    if (send_data !== 8'hA5) begin nfail++; $display("FAIL idle_status got %h want a5", send_data); end
    if (busy !== 1'b0) begin nfail++; $display("FAIL idle_busy got %b want 0", busy); end
    idle(4);
  endtask

  task automatic test_write();
    logic [7:0] m;
    int w0 = wn;
    frame_start();
    nvec++;
    if (busy !== 1'b1) begin nfail++; $display("FAIL wr_busy got %b want 1", busy); end
    send_byte(8'h05, m);
    send_byte(8'h3C, m);
    nvec += 3;
    if (reg_we !== 1'b1) begin nfail++; $display("FAIL wr_we_timing got %b want 1", reg_we); end
    if (reg_addr !== 7'h05) begin nfail++; $display("FAIL wr_addr got %h want 05", reg_addr); end
    if (reg_wdata !== 8'h3C) begin nfail++; $display("FAIL wr_data got %h want 3c", reg_wdata); end
    idle(1);
    nvec++;
    if (reg_we !== 1'b0) begin nfail++; $display("FAIL wr_we_pulse got %b want 0", reg_we); end
    frame_end();
    nvec += 2;
    if (wn - w0 !== 1) begin nfail++; $display("FAIL wr_count got %0d want 1", wn - w0); end
    if (busy !== 1'b0) begin nfail++; $display("FAIL wr_end_busy got %b want 0", busy); end
    mem[5] = 8'h3C;
  endtask

  task automatic test_read();
    int r0 = rn;
    mem[7'h0A] = 8'h77;
    fb[0] = 8'h8A; fb[1] = 8'($urandom); fb[2] = 8'($urandom);
    do_frame(3);
    nvec += 5;
    if (mo[0] !== 8'hA5) begin nfail++; $display("FAIL rd_miso0 got %h want a5", mo[0]); end
    if (mo[1] !== 8'h00) begin nfail++; $display("FAIL rd_miso1 got %h want 00", mo[1]); end
    if (mo[2] !== 8'h77) begin nfail++; $display("FAIL rd_miso2 got %h want 77", mo[2]); end
    if (rn - r0 !== (BURST ? 3 : 1)) begin nfail++; $display("FAIL rd_count got %0d want %0d", rn - r0, BURST ? 3 : 1); end
    if (ra[r0 % 256] !== 7'h0A) begin nfail++; $display("FAIL rd_addr got %h want 0a", ra[r0 % 256]); end
  endtask

  task automatic test_wrap();
    int w0 = wn;
    int ew = BURST ? 2 : 1;
    logic [AW-1:0] xa [2];
    logic [7:0]    xd [2];
    xa[0] = 7'h7F; xd[0] = 8'h11; xa[1] = 7'h00; xd[1] = 8'h22;
    fb[0] = 8'h7F; fb[1] = 8'h11; fb[2] = 8'h22;
    do_frame(3);
    nvec++;
    if (wn - w0 !== ew) begin nfail++; $display("FAIL wrap_count got %0d want %0d", wn - w0, ew); end
    for (int i = 0; i < ew; i++) begin
      nvec++;
      if (wa[(w0+i) % 256] !== xa[i] || wd[(w0+i) % 256] !== xd[i]) begin
        nfail++; $display("FAIL wrap_write%0d got %h=%h want %h=%h", i, wa[(w0+i) % 256], wd[(w0+i) % 256], xa[i], xd[i]);
      end
      mem[xa[i]] = xd[i];
    end
  endtask

  task automatic test_partial();
    logic [7:0] m;
    int w0 = wn;
    frame_start();
    send_byte(8'h05, m);
    idle(5);
    ss = 1'b1; send_ready = 1'b1;
    idle(6);
    nvec += 2;
    if (wn - w0 !== 0) begin nfail++; $display("FAIL partial_we got %0d writes want 0", wn - w0); end
    if (busy !== 1'b0) begin nfail++; $display("FAIL partial_busy got %b want 0", busy); end
    frame_start();
    send_byte(8'h8A, m);
    idle(5);
    ss = 1'b1; send_ready = 1'b1;
    idle(6);
    nvec += 2;
    if (send_data !== 8'hA5) begin nfail++; $display("FAIL partial_status got %h want a5", send_data); end
    if (busy !== 1'b0) begin nfail++; $display("FAIL partial_rd_busy got %b want 0", busy); end
  endtask

  task automatic test_idle_glitch();
    logic [7:0] m;
    int w0 = wn, r0 = rn;
    send_byte(8'h85, m);
    send_byte(8'h3C, m);
    send_ready = 1'b1;
    idle(4);
    nvec += 2;
    if (wn - w0 !== 0 || rn - r0 !== 0) begin nfail++; $display("FAIL glitch_strobes got we=%0d re=%0d want 0 0", wn - w0, rn - r0); end
    if (busy !== 1'b0 || send_data !== 8'hA5) begin nfail++; $display("FAIL glitch_idle got busy=%b sd=%h want 0 a5", busy, send_data); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] m;
    int w0, r0;
    frame_start();
    send_byte(8'h8A, m);
    idle(3);
    rst = 1'b1;
    idle(2);
    nvec += 3;
    if (send_data !== 8'h00 || reg_addr !== '0 || reg_wdata !== 8'h00) begin
      nfail++; $display("FAIL midrst_data got sd=%h a=%h wd=%h want 00 00 00", send_data, reg_addr, reg_wdata);
    end
    if (reg_we !== 1'b0 || reg_re !== 1'b0) begin nfail++; $display("FAIL midrst_strobes got we=%b re=%b want 0 0", reg_we, reg_re); end
    if (busy !== 1'b0) begin nfail++; $display("FAIL midrst_busy got %b want 0", busy); end
    rst = 1'b0;
    w0 = wn; r0 = rn;
    idle(4);
    send_byte(8'h05, m);
    send_byte(8'h3C, m);
    idle(3);
    nvec += 2;
    if (busy !== 1'b0) begin nfail++; $display("FAIL midrst_stay_idle got busy=%b want 0", busy); end
    if (wn - w0 !== 0 || rn - r0 !== 0) begin nfail++; $display("FAIL midrst_nostrobe got we=%0d re=%0d want 0 0", wn - w0, rn - r0); end
    frame_end();
    w0 = wn;
    fb[0] = 8'h12; fb[1] = 8'h5A;
    do_frame(2);
    nvec += 2;
    if (wn - w0 !== 1) begin nfail++; $display("FAIL midrst_next_count got %0d want 1", wn - w0); end
    if (wa[w0 % 256] !== 7'h12 || wd[w0 % 256] !== 8'h5A) begin
      nfail++; $display("FAIL midrst_next_write got %h=%h want 12=5a", wa[w0 % 256], wd[w0 % 256]);
    end
    mem[7'h12] = 8'h5A;
  endtask

  task automatic test_random();
    for (int f = 0; f < 30; f++) begin
      int n = $urandom_range(1, 5);
      int w0 = wn, r0 = rn;
      logic [AW-1:0] a;
      logic rd;
      int ew, er;
      for (int k = 0; k < 8; k++) fb[k] = 8'($urandom);
      a  = fb[0][AW-1:0];
      rd = fb[0][7];
      ew = rd ? 0 : (BURST ? n - 1 : (n >= 2 ? 1 : 0));
      er = rd ? (BURST ? n : 1) : 0;
      do_frame(n);
      nvec += 3;
      if (wn - w0 !== ew) begin nfail++; $display("FAIL rnd%0d_wcount got %0d want %0d", f, wn - w0, ew); end
      if (rn - r0 !== er) begin nfail++; $display("FAIL rnd%0d_rcount got %0d want %0d", f, rn - r0, er); end
      if (mo[0] !== 8'hA5) begin nfail++; $display("FAIL rnd%0d_status got %h want a5", f, mo[0]); end
      for (int i = 0; i < ew; i++) begin
        logic [AW-1:0] xa = AW'(a + i);
        nvec++;
        if (wa[(w0+i) % 256] !== xa || wd[(w0+i) % 256] !== fb[i+1]) begin
          nfail++; $display("FAIL rnd%0d_write%0d got %h=%h want %h=%h", f, i, wa[(w0+i) % 256], wd[(w0+i) % 256], xa, fb[i+1]);
        end
        mem[xa] = fb[i+1];
      end
      for (int i = 0; i < er; i++) begin
        nvec++;
        if (ra[(r0+i) % 256] !== AW'(a + i)) begin nfail++; $display("FAIL rnd%0d_read%0d got %h want %h", f, i, ra[(r0+i) % 256], AW'(a + i)); end
      end
      if (rd) begin
        nvec++;
        if (mo[1] !== 8'h00) begin nfail++; $display("FAIL rnd%0d_turn got %h want 00", f, mo[1]); end
        for (int k = 2; k <= n; k++)
          if (BURST || k == 2) begin
            nvec++;
            if (mo[k] !== mem[AW'(a + k - 2)]) begin nfail++; $display("FAIL rnd%0d_miso%0d got %h want %h", f, k, mo[k], mem[AW'(a + k - 2)]); end
          end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
    test_reset();
    test_write();
    test_read();
    test_wrap();
    test_partial();
    test_idle_glitch();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout after %0d vectors", nvec);
    $fatal(1, "timeout");
  end
endmodule
